// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: segment glyphs and the
// select_time field encodings.
package clock_pkg;

   // Segment vectors are {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_GLYPH [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   // Field under edit as driven by Clock_display.
   typedef enum logic [1:0] {
      SEL_SEC  = 2'd0,
      SEL_MIN  = 2'd1,
      SEL_HOUR = 2'd2,
      SEL_NONE = 2'd3
   } sel_t;

   // Blink phase of the field being edited.
   typedef enum logic {
      PHASE_VISIBLE = 1'b0,
      PHASE_HIDDEN  = 1'b1
   } phase_t;

   localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder. Codes above 9 render as a dash
// so a corrupted digit is visibly wrong instead of showing a random glyph.
module bcd_to_seg7
   import clock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup for valid BCD, dash otherwise.
   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9) begin
         seg = SEG_GLYPH[bcd];
      end
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for the 8-anode common-anode display. Scans the six
// time digits, blinks the field under edit, and keeps every anode off for a
// short guard interval at the start of each slot to avoid ghosting.
module seg7_scan_display
   import clock_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int GUARD     = 16,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk_100MHz,
   input  logic       rst_n,
   input  logic [3:0] L_sec,
   input  logic [3:0] H_sec,
   input  logic [3:0] L_min,
   input  logic [3:0] H_min,
   input  logic [3:0] L_hour,
   input  logic [3:0] H_hour,
   input  logic [1:0] select_time,
   input  logic       change_out,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   GUARD_C   = CNT_W'(GUARD);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

   // Reject parameter sets that would break the slot timing.
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_scan_display: SCAN_DIV must be at least 2");
   end
   if ((GUARD < 0) || (GUARD >= SCAN_DIV)) begin : g_bad_guard
      $error("seg7_scan_display: GUARD must be in 0..SCAN_DIV-1");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("seg7_scan_display: BLINK_DIV must be at least 1");
   end

   // Scan state.
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic [3:0]         snap_q, snap_d;
   logic               snap_vld_q, snap_vld_d;
   // Blink state.
   logic [BLINK_W-1:0] bcnt_q, bcnt_d;
   phase_t             phase_q, phase_d;
   logic               chg_q, chg_d;
   // Output registers.
   logic [7:0]         an_q, an_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;

   logic [3:0]         digit_sel;
   logic [6:0]         seg_dec;

   // Digit feeding the snapshot: the one belonging to the upcoming slot.
   always_comb begin
      case (idx_d)
         3'd0:    digit_sel = L_sec;
         3'd1:    digit_sel = H_sec;
         3'd2:    digit_sel = L_min;
         3'd3:    digit_sel = H_min;
         3'd4:    digit_sel = L_hour;
         3'd5:    digit_sel = H_hour;
         default: digit_sel = L_sec;
      endcase
   end

   // Slot counter, position index and snapshot capture. The snapshot is also
   // loaded on the first clock after reset so slot 0 shows a real digit.
   always_comb begin
      logic load;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      snap_vld_d = 1'b1;
      load       = ~snap_vld_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         load  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      if (load) begin
         snap_d = digit_sel;
      end
   end

   // Blink counter and phase. A rising edge of change_out restarts the
   // half-period from zero with the field visible.
   always_comb begin
      logic               rise;
      logic [BLINK_W-1:0] bcnt_cur;
      phase_t             phase_cur;
      chg_d     = change_out;
      rise      = change_out & ~chg_q;
      bcnt_cur  = rise ? '0 : bcnt_q;
      phase_cur = rise ? PHASE_VISIBLE : phase_q;
      if (!change_out) begin
         bcnt_d  = '0;
         phase_d = PHASE_VISIBLE;
      end else if (bcnt_cur == BLINK_MAX) begin
         bcnt_d  = '0;
         phase_d = (phase_cur == PHASE_HIDDEN) ? PHASE_VISIBLE : PHASE_HIDDEN;
      end else begin
         bcnt_d  = bcnt_cur + 1'b1;
         phase_d = phase_cur;
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (snap_q),
      .seg (seg_dec)
   );

   // Next output values from the current scan/blink state and live edit inputs.
   always_comb begin
      logic in_field;
      logic blank;
      logic an_on;
      case (sel_t'(select_time))
         SEL_SEC:  in_field = (idx_q == 3'd0) || (idx_q == 3'd1);
         SEL_MIN:  in_field = (idx_q == 3'd2) || (idx_q == 3'd3);
         SEL_HOUR: in_field = (idx_q == 3'd4) || (idx_q == 3'd5);
         default:  in_field = 1'b0;
      endcase
      blank = change_out && (phase_q == PHASE_HIDDEN) && in_field;
      an_on = (cnt_q >= GUARD_C) && !blank;
      an_d  = an_on ? ~(8'd1 << idx_q) : 8'hFF;
      seg_d = (blank || !snap_vld_q) ? SEG_BLANK : seg_dec;
      // Separator dot only lit together with its own anode.
      dp_d  = ~(an_on && ((idx_q == 3'd2) || (idx_q == 3'd4)));
   end

   // State and output registers.
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         snap_q     <= 4'd0;
         snap_vld_q <= 1'b0;
         bcnt_q     <= '0;
         phase_q    <= PHASE_VISIBLE;
         chg_q      <= 1'b0;
         an_q       <= 8'hFF;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         snap_vld_q <= snap_vld_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         chg_q      <= chg_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
